// File: rtl/switch_bounce_gen.sv
// Bouncing-switch emulator: turns a clean level into an LFSR-driven burst of
// contact bounces followed by a settle period, for exercising debouncers.
module switch_bounce_gen #(
    parameter int unsigned T_UNIT   = 10_000,
    parameter int unsigned SETTLE_T = 2_000_000,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int unsigned TMR_W    = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clean_in,
    input  logic en,
    output logic sw_out,
    output logic busy,
    output logic done
);

    localparam logic [15:0] TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE
    } state_t;

    state_t             state;
    logic               level;
    logic [15:0]        lfsr;
    logic [TMR_W-1:0]   timer;
    logic [3:0]         toggles_left;

    logic [15:0]        lfsr_next;
    logic [TMR_W-1:0]   rand_interval;
    logic [3:0]         rand_toggles;
    logic               timer_expired;

    // Galois step plus the random fields drawn from the current LFSR value
    always_comb begin
        lfsr_next     = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
        rand_interval = TMR_W'((32'(lfsr[3:0]) + 32'd1) * T_UNIT);
        rand_toggles  = {1'b0, lfsr[1:0], 1'b0} + 4'd2;
        timer_expired = (timer <= TMR_W'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            level        <= 1'b0;
            sw_out       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            lfsr         <= SEED;
            timer        <= '0;
            toggles_left <= '0;
        end else begin
            lfsr <= lfsr_next;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clean_in != level) begin
                        level  <= clean_in;
                        sw_out <= clean_in;
                        if (en) begin
                            toggles_left <= rand_toggles;
                            timer        <= rand_interval;
                            busy         <= 1'b1;
                            state        <= BOUNCE;
                        end
                    end
                end
                BOUNCE: begin
                    if (timer_expired) begin
                        sw_out       <= ~sw_out;
                        toggles_left <= toggles_left - 4'd1;
                        // Even toggle count guarantees sw_out lands back on level here
                        if (toggles_left == 4'd1) begin
                            timer <= TMR_W'(SETTLE_T);
                            state <= SETTLE;
                        end else begin
                            timer <= rand_interval;
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                SETTLE: begin
                    if (timer_expired) begin
                        timer <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
